// File: rtl/wb_arb_pkg.sv
// Shared constants and types for the register-file write-back port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_arb_pkg;

   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_NOP    = 7'b0010011;

   // Idle beat: rd=0 makes a stray RF write target x0, which ignores it.
   localparam logic [4:0] NOP_RD = 5'd0;

   typedef enum logic {
      ARB    = 1'b0,
      STARVE = 1'b1
   } arb_state_t;

   // Stores and branches retire without writing the RF, so they leave the port free.
   function automatic logic op_writes_rf(input logic [6:0] op);
      return (op != OP_STORE) && (op != OP_BRANCH);
   endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundles retire-slot, long-latency-unit and RF write-back signals of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: units via unit_valid/unit_ready, retire slot only via stall_pipe.
interface wb_port_arbiter_if #(
   parameter int NUNITS = 2,
   parameter int XLEN   = 64
);
   logic                     pipe_valid;
   logic [4:0]               pipe_rd;
   logic [6:0]               pipe_opcode;
   logic [XLEN-1:0]          pipe_data;

   logic [NUNITS-1:0]        unit_valid;
   logic [NUNITS-1:0]        unit_ready;
   logic [5*NUNITS-1:0]      unit_rd;
   logic [7*NUNITS-1:0]      unit_opcode;
   logic [XLEN*NUNITS-1:0]   unit_data;

   logic                     wb_valid;
   logic [4:0]               wrd;
   logic [6:0]               wopcode;
   logic [XLEN-1:0]          wdata;
   logic                     stall_pipe;

   // Requester side: pipeline plus long-latency units.
   modport master (
      output pipe_valid, pipe_rd, pipe_opcode, pipe_data,
      output unit_valid, unit_rd, unit_opcode, unit_data,
      input  unit_ready,
      input  wb_valid, wrd, wopcode, wdata, stall_pipe
   );

   // Arbiter side.
   modport slave (
      input  pipe_valid, pipe_rd, pipe_opcode, pipe_data,
      input  unit_valid, unit_rd, unit_opcode, unit_data,
      output unit_ready,
      output wb_valid, wrd, wopcode, wdata, stall_pipe
   );
endinterface

// File: rtl/wb_rr_picker.sv
// Round-robin pick: first requester at or above ptr (wrapping) gets a one-hot grant.
// Latency: purely combinational.
// Backpressure: none; caller decides whether the pick is actually granted.
module wb_rr_picker #(
   parameter int NUNITS = 2,
   parameter int PW     = 1
) (
   input  logic [NUNITS-1:0] req,
   input  logic [PW-1:0]     ptr,
   output logic [NUNITS-1:0] gnt,
   output logic [PW-1:0]     gnt_idx,
   output logic [PW-1:0]     ptr_nxt,
   output logic              any
);

   // Walk NUNITS slots starting at ptr; the first requesting slot wins.
   always_comb begin
      int k;
      k       = 0;
      gnt     = '0;
      gnt_idx = '0;
      ptr_nxt = ptr;
      any     = 1'b0;
      for (int n = 0; n < NUNITS; n++) begin
         k = (int'(ptr) + n) % NUNITS;
         if (!any && req[k]) begin
            any     = 1'b1;
            gnt[k]  = 1'b1;
            gnt_idx = PW'(k);
            ptr_nxt = PW'((k + 1) % NUNITS);
         end
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the RF write port between the retire slot (priority) and NUNITS round-robin units.
// Latency: winner accepted in cycle N drives wb_* in cycle N+1; one beat per cycle.
// Backpressure: units via unit_ready; retire slot via stall_pipe after MAX_WAIT blocked cycles.
// Optional WB_ARB_PERF_EN adds saturating perf_conflicts / perf_stalls counters.
module wb_port_arbiter
   import wb_arb_pkg::*;
#(
   parameter int NUNITS   = 2,
   parameter int XLEN     = 64,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   wb_port_arbiter_if.slave  bus
`ifdef WB_ARB_PERF_EN
   ,
   output logic [31:0]       perf_conflicts,
   output logic [31:0]       perf_stalls
`endif
);

   localparam int PW = (NUNITS > 1) ? $clog2(NUNITS) : 1;
   localparam int WW = $clog2(MAX_WAIT + 1);

   arb_state_t        state, state_nxt;
   logic [WW-1:0]     wait_cnt, wait_nxt;
   logic [PW-1:0]     rr_ptr, ptr_nxt;
   logic [PW-1:0]     pick_idx, pick_ptr_nxt;
   logic [NUNITS-1:0] pick_gnt;
   logic              pick_any;
   logic              pipe_occ, pipe_win, unit_win;

   logic              wb_valid_q;
   logic [4:0]        wrd_q;
   logic [6:0]        wopcode_q;
   logic [XLEN-1:0]   wdata_q;

   assign pipe_occ = bus.pipe_valid && op_writes_rf(bus.pipe_opcode);

   wb_rr_picker #(
      .NUNITS (NUNITS),
      .PW     (PW)
   ) u_picker (
      .req     (bus.unit_valid),
      .ptr     (rr_ptr),
      .gnt     (pick_gnt),
      .gnt_idx (pick_idx),
      .ptr_nxt (pick_ptr_nxt),
      .any     (pick_any)
   );

   // Decide the winner and advance the starvation FSM / round-robin pointer.
   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      ptr_nxt   = rr_ptr;
      // In STARVE the retire slot is frozen upstream, so its request is ignored.
      pipe_win  = (state == ARB) && pipe_occ;
      // Gated by rst_n so no grant is visible while reset is asserted.
      unit_win  = rst_n && pick_any && !pipe_win;
      case (state)
         ARB: begin
            if (unit_win) begin
               wait_nxt = '0;
            end else if (|bus.unit_valid) begin
               if (wait_cnt == WW'(MAX_WAIT - 1)) begin
                  state_nxt = STARVE;
               end else begin
                  wait_nxt = wait_cnt + 1'b1;
               end
            end
         end
         STARVE: begin
            // Either a unit is served this cycle or none is waiting; both end the stall.
            state_nxt = ARB;
            wait_nxt  = '0;
         end
      endcase
      if (unit_win) begin
         ptr_nxt = pick_ptr_nxt;
      end
   end

   assign bus.unit_ready = unit_win ? pick_gnt : '0;

   // FSM, blocked-cycle counter and round-robin pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ARB;
         wait_cnt <= '0;
         rr_ptr   <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         rr_ptr   <= ptr_nxt;
      end
   end

   // Register the winning beat; idle cycles present a harmless NOP to the RF.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid_q <= 1'b0;
         wrd_q      <= NOP_RD;
         wopcode_q  <= OP_NOP;
         wdata_q    <= '0;
      end else if (unit_win) begin
         wb_valid_q <= 1'b1;
         wrd_q      <= bus.unit_rd[5*int'(pick_idx) +: 5];
         wopcode_q  <= bus.unit_opcode[7*int'(pick_idx) +: 7];
         wdata_q    <= bus.unit_data[XLEN*int'(pick_idx) +: XLEN];
      end else if (pipe_win) begin
         wb_valid_q <= 1'b1;
         wrd_q      <= bus.pipe_rd;
         wopcode_q  <= bus.pipe_opcode;
         wdata_q    <= bus.pipe_data;
      end else begin
         wb_valid_q <= 1'b0;
         wrd_q      <= NOP_RD;
         wopcode_q  <= OP_NOP;
         wdata_q    <= '0;
      end
   end

   assign bus.wb_valid   = wb_valid_q;
   assign bus.wrd        = wrd_q;
   assign bus.wopcode    = wopcode_q;
   assign bus.wdata      = wdata_q;
   // The state register already is the registered stall indication.
   assign bus.stall_pipe = (state == STARVE);

`ifdef WB_ARB_PERF_EN
   // Count unit-vs-pipe conflicts and stalled cycles, saturating at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_conflicts <= '0;
         perf_stalls    <= '0;
      end else begin
         if (pipe_win && (|bus.unit_valid) && (perf_conflicts != '1)) begin
            perf_conflicts <= perf_conflicts + 32'd1;
         end
         if ((state == STARVE) && (perf_stalls != '1)) begin
            perf_stalls <= perf_stalls + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table, corner sequences, random vs model.
// Latency: checks wb_* one cycle after acceptance, unit_ready within the cycle.
// Backpressure: units hold requests until granted; retire slot holds while stalled.
module tb_wb_port_arbiter;
   import wb_arb_pkg::*;

   localparam int NUNITS   = 2;
   localparam int XLEN     = 64;
   localparam int MAX_WAIT = 4;
   localparam logic [6:0] U0_OP = 7'b0000011;
   localparam logic [6:0] U1_OP = 7'b0111011;
   localparam logic [6:0] OP_ALU = 7'b0110011;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   wb_port_arbiter_if #(.NUNITS(NUNITS), .XLEN(XLEN)) bus ();

`ifdef WB_ARB_PERF_EN
   logic [31:0] perf_conflicts, perf_stalls;
`endif

   wb_port_arbiter #(
      .NUNITS   (NUNITS),
      .XLEN     (XLEN),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
`ifdef WB_ARB_PERF_EN
      ,
      .perf_conflicts (perf_conflicts),
      .perf_stalls    (perf_stalls)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   int                m_ptr, m_blocked;
   bit                m_starve;
   logic [NUNITS-1:0] m_ready;
   logic              e_valid, e_stall;
   logic [4:0]        e_rd;
   logic [6:0]        e_op;
   logic [63:0]       e_data;

   typedef struct {
      string       name;
      logic        pv;
      logic [4:0]  prd;
      logic [6:0]  pop;
      logic [63:0] pdat;
      logic [1:0]  uv;
      logic [4:0]  u0rd;
      logic [63:0] u0dat;
      logic [4:0]  u1rd;
      logic [63:0] u1dat;
      logic [1:0]  x_ready;
      logic        x_valid;
      logic [4:0]  x_rd;
      logic [6:0]  x_op;
      logic [63:0] x_dat;
   } vec_t;

   vec_t vt[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_unit(input int i, input logic v, input logic [4:0] rd,
                           input logic [6:0] op, input logic [63:0] dat);
      bus.unit_valid[i]          = v;
      bus.unit_rd[5*i +: 5]      = rd;
      bus.unit_opcode[7*i +: 7]  = op;
      bus.unit_data[64*i +: 64]  = dat;
   endtask

   task automatic set_pipe(input logic v, input logic [4:0] rd, input logic [6:0] op,
                           input logic [63:0] dat);
      bus.pipe_valid  = v;
      bus.pipe_rd     = rd;
      bus.pipe_opcode = op;
      bus.pipe_data   = dat;
   endtask

   task automatic drive_idle();
      set_pipe(1'b0, 5'd0, OP_NOP, 64'd0);
      for (int i = 0; i < NUNITS; i++) set_unit(i, 1'b0, 5'd0, 7'd0, 64'd0);
   endtask

   // Returns right after a falling edge with reset released.
   task automatic do_reset();
      rst_n = 1'b0;
      drive_idle();
      repeat (2) @(negedge clk);
      rst_n     = 1'b1;
      m_ptr     = 0;
      m_blocked = 0;
      m_starve  = 0;
   endtask

   // One cycle of the port rules, from the inputs currently driven.
   task automatic model_step();
      bit occ;
      int win;
      occ = bus.pipe_valid && (bus.pipe_opcode != OP_STORE) && (bus.pipe_opcode != OP_BRANCH);
      win = -1;
      if (m_starve || !occ) begin
         for (int n = 0; n < NUNITS; n++) begin
            if (win < 0 && bus.unit_valid[(m_ptr + n) % NUNITS]) win = (m_ptr + n) % NUNITS;
         end
      end
      m_ready = '0;
      if (win >= 0) begin
         m_ready[win] = 1'b1;
         e_valid   = 1'b1;
         e_rd      = bus.unit_rd[5*win +: 5];
         e_op      = bus.unit_opcode[7*win +: 7];
         e_data    = bus.unit_data[64*win +: 64];
         m_ptr     = (win + 1) % NUNITS;
         m_blocked = 0;
         m_starve  = 0;
      end else if (!m_starve && occ) begin
         e_valid = 1'b1;
         e_rd    = bus.pipe_rd;
         e_op    = bus.pipe_opcode;
         e_data  = bus.pipe_data;
         if (bus.unit_valid != '0) begin
            m_blocked++;
            if (m_blocked >= MAX_WAIT) m_starve = 1;
         end
      end else begin
         e_valid   = 1'b0;
         e_rd      = 5'd0;
         e_op      = OP_NOP;
         e_data    = 64'd0;
         m_starve  = 0;
         m_blocked = (bus.unit_valid == '0 && m_starve) ? 0 : m_blocked;
      end
      e_stall = m_starve;
   endtask

   initial begin
      logic [NUNITS-1:0] drop;
      logic [6:0] pops [5];
      pops = '{OP_ALU, OP_NOP, OP_STORE, OP_BRANCH, 7'b0000011};

      vt[0] = '{"pipe_only", 1'b1, 5'd5, OP_ALU, 64'hAB, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0,
                2'b00, 1'b1, 5'd5, OP_ALU, 64'hAB};
      vt[1] = '{"store_bypass", 1'b1, 5'd9, OP_STORE, 64'h55, 2'b01, 5'd7, 64'd1, 5'd0, 64'd0,
                2'b01, 1'b1, 5'd7, U0_OP, 64'd1};
      vt[2] = '{"rd0_unit", 1'b0, 5'd0, OP_NOP, 64'd0, 2'b01, 5'd0, 64'hFF, 5'd0, 64'd0,
                2'b01, 1'b1, 5'd0, U0_OP, 64'hFF};
      vt[3] = '{"branch_bypass_u1", 1'b1, 5'd3, OP_BRANCH, 64'h9, 2'b10, 5'd0, 64'd0, 5'd12, 64'h1234,
                2'b10, 1'b1, 5'd12, U1_OP, 64'h1234};
      vt[4] = '{"idle", 1'b0, 5'd6, OP_ALU, 64'h66, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0,
                2'b00, 1'b0, 5'd0, OP_NOP, 64'd0};
      vt[5] = '{"pipe_over_units", 1'b1, 5'd4, OP_NOP, 64'h77, 2'b11, 5'd1, 64'h11, 5'd2, 64'h22,
                2'b00, 1'b1, 5'd4, OP_NOP, 64'h77};
      vt[6] = '{"both_units_ptr0", 1'b0, 5'd0, OP_NOP, 64'd0, 2'b11, 5'd1, 64'h11, 5'd2, 64'h22,
                2'b01, 1'b1, 5'd1, U0_OP, 64'h11};

      // reset values while units are requesting
      rst_n = 1'b0;
      drive_idle();
      set_unit(0, 1'b1, 5'd3, U0_OP, 64'h3);
      set_unit(1, 1'b1, 5'd4, U1_OP, 64'h4);
      #12;
      chk("rst_ready", 64'(bus.unit_ready), 64'd0);
      chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
      chk("rst_wrd", 64'(bus.wrd), 64'd0);
      chk("rst_wopcode", 64'(bus.wopcode), 64'(OP_NOP));
      chk("rst_wdata", bus.wdata, 64'd0);
      chk("rst_stall", 64'(bus.stall_pipe), 64'd0);

      // single-cycle vectors from a fresh reset
      foreach (vt[v]) begin
         do_reset();
         set_pipe(vt[v].pv, vt[v].prd, vt[v].pop, vt[v].pdat);
         set_unit(0, vt[v].uv[0], vt[v].u0rd, U0_OP, vt[v].u0dat);
         set_unit(1, vt[v].uv[1], vt[v].u1rd, U1_OP, vt[v].u1dat);
         #1;
         chk({vt[v].name, "_ready"}, 64'(bus.unit_ready), 64'(vt[v].x_ready));
         @(negedge clk);
         chk({vt[v].name, "_valid"}, 64'(bus.wb_valid), 64'(vt[v].x_valid));
         chk({vt[v].name, "_wrd"}, 64'(bus.wrd), 64'(vt[v].x_rd));
         chk({vt[v].name, "_wopcode"}, 64'(bus.wopcode), 64'(vt[v].x_op));
         chk({vt[v].name, "_wdata"}, bus.wdata, vt[v].x_dat);
         chk({vt[v].name, "_stall"}, 64'(bus.stall_pipe), 64'd0);
         drive_idle();
      end

      // round-robin fairness with both units always requesting
      do_reset();
      set_unit(0, 1'b1, 5'd1, U0_OP, 64'h10);
      set_unit(1, 1'b1, 5'd2, U1_OP, 64'h20);
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("rr_ready", 64'(bus.unit_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
         @(negedge clk);
         chk("rr_wrd", 64'(bus.wrd), (i % 2 == 0) ? 64'd1 : 64'd2);
         chk("rr_stall", 64'(bus.stall_pipe), 64'd0);
      end

      // starvation: pipe writes every cycle, unit1 waits
      do_reset();
      for (int cyc = 1; cyc <= 7; cyc++) begin
         if (cyc > 1) @(negedge clk);
         chk("starve_stall", 64'(bus.stall_pipe), (cyc == 5) ? 64'd1 : 64'd0);
         if (cyc >= 2) begin
            chk("starve_wrd", 64'(bus.wrd), (cyc == 6) ? 64'd25 : 64'(10 + cyc - 1));
            chk("starve_valid", 64'(bus.wb_valid), 64'd1);
         end
         if (cyc == 6) chk("starve_wdata", bus.wdata, 64'hC0DE);
         if (cyc != 5) set_pipe(1'b1, 5'(10 + cyc), OP_ALU, 64'(cyc));
         set_unit(1, (cyc <= 5), 5'd25, U1_OP, 64'hC0DE);
         #1;
         chk("starve_ready", 64'(bus.unit_ready), (cyc == 5) ? 64'd2 : 64'd0);
      end
      drive_idle();

      // asynchronous reset in the middle of a grant
      do_reset();
      set_unit(0, 1'b1, 5'd8, U0_OP, 64'h8);
      set_unit(1, 1'b1, 5'd9, U1_OP, 64'h9);
      #1;
      chk("mid_ready0", 64'(bus.unit_ready), 64'd1);
      @(negedge clk);
      chk("mid_valid_pre", 64'(bus.wb_valid), 64'd1);
      #1;
      chk("mid_ready1", 64'(bus.unit_ready), 64'd2);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", 64'(bus.unit_ready), 64'd0);
      chk("mid_rst_valid", 64'(bus.wb_valid), 64'd0);
      chk("mid_rst_wrd", 64'(bus.wrd), 64'd0);
      chk("mid_rst_wopcode", 64'(bus.wopcode), 64'(OP_NOP));
      chk("mid_rst_wdata", bus.wdata, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid_rr_restart", 64'(bus.unit_ready), 64'd1);
      @(negedge clk);
      drive_idle();

      // randomized traffic against the reference model
      do_reset();
      drop = '0;
      for (int c = 0; c < 500; c++) begin
         if (c > 0) begin
            @(negedge clk);
            chk("rnd_valid", 64'(bus.wb_valid), 64'(e_valid));
            chk("rnd_wrd", 64'(bus.wrd), 64'(e_rd));
            chk("rnd_wopcode", 64'(bus.wopcode), 64'(e_op));
            chk("rnd_wdata", bus.wdata, e_data);
            chk("rnd_stall", 64'(bus.stall_pipe), 64'(e_stall));
         end
         bus.unit_valid = bus.unit_valid & ~drop;
         if (!bus.stall_pipe) begin
            set_pipe(($urandom_range(0, 9) < 6), 5'($urandom), pops[$urandom_range(0, 4)],
                     {$urandom, $urandom});
         end
         for (int i = 0; i < NUNITS; i++) begin
            if (!bus.unit_valid[i] && $urandom_range(0, 2) != 0)
               set_unit(i, 1'b1, 5'($urandom), 7'($urandom), {$urandom, $urandom});
         end
         model_step();
         #1;
         chk("rnd_ready", 64'(bus.unit_ready), 64'(m_ready));
         drop = bus.unit_ready;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
